// File: rtl/rheed_pkg.sv
// Shared state type, header constant and sizing helpers for the prediction packer.
package rheed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2
    } pack_state_t;

    localparam logic [31:0] HDR_MAGIC = 32'h52484544; // "RHED"

    function automatic int unsigned calc_lanes(input int unsigned out_w,
                                               input int unsigned pix_w);
        return out_w / pix_w;
    endfunction

    function automatic int unsigned calc_beats(input int unsigned num_samples,
                                               input int unsigned lanes);
        return (num_samples + lanes - 1) / lanes;
    endfunction

    // Byte count of the final beat; a full beat when the frame divides evenly into lanes.
    function automatic int unsigned calc_last_bytes(input int unsigned num_samples,
                                                    input int unsigned lanes,
                                                    input int unsigned pix_w);
        int unsigned rem;
        rem = num_samples % lanes;
        if (rem == 0) rem = lanes;
        return rem * pix_w / 8;
    endfunction

    function automatic logic [95:0] hdr_word(input logic [31:0] frame_cnt,
                                             input logic [15:0] num_samples);
        logic [95:0] w;
        w        = '0;
        w[31:0]  = frame_cnt;
        w[47:32] = num_samples;
        w[95:64] = HDR_MAGIC;
        return w;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream output register: loads a beat when free, holds it stable until tready.
module axis_out_reg #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned KEEP_W = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [KEEP_W-1:0] keep_i,
    input  logic              last_i,
    output logic              free_o,
    output logic              tvalid_o,
    input  logic              tready_i,
    output logic [DATA_W-1:0] tdata_o,
    output logic [KEEP_W-1:0] tkeep_o,
    output logic              tlast_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [KEEP_W-1:0] keep_q, keep_d;
    logic              last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            keep_d  = keep_i;
            last_d  = last_i;
        end else if (tready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    // Free when empty or when the held beat leaves on this edge.
    assign free_o   = !valid_q || tready_i;
    assign tvalid_o = valid_q;
    assign tdata_o  = data_q;
    assign tkeep_o  = keep_q;
    assign tlast_o  = last_q;

endmodule

// File: rtl/prediction_packer.sv
// Packs the 8-bit prediction stream into 256-bit AXI-Stream beats, one frame per ap_start.
// Define FRAME_HEADER_EN to prefix every frame with a header beat (frame count, size, magic).
module prediction_packer
    import rheed_pkg::*;
#(
    parameter int unsigned PIXEL_BIT_WIDTH = 8,
    parameter int unsigned OUT_WIDTH       = 256,
    parameter int unsigned NUM_SAMPLES     = 64,
    parameter int unsigned FRAME_CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ap_start,
    output logic                       ap_done,
    output logic                       ap_idle,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [OUT_WIDTH-1:0]       m_axis_tdata,
    output logic [OUT_WIDTH/8-1:0]     m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic [FRAME_CNT_W-1:0]     frame_cnt
);

    localparam int unsigned LANES      = calc_lanes(OUT_WIDTH, PIXEL_BIT_WIDTH);
    localparam int unsigned KEEP_W     = OUT_WIDTH / 8;
    localparam int unsigned LAST_BYTES = calc_last_bytes(NUM_SAMPLES, LANES, PIXEL_BIT_WIDTH);
    localparam int unsigned LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned SMP_W      = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [KEEP_W-1:0] LAST_KEEP = {KEEP_W{1'b1}} >> (KEEP_W - LAST_BYTES);

    pack_state_t            state_q, state_d;
    logic [LANE_W-1:0]      lane_cnt_q, lane_cnt_d;
    logic [SMP_W-1:0]       smp_cnt_q, smp_cnt_d;
    logic [OUT_WIDTH-1:0]   acc_q, acc_d;
    logic                   acc_full_q, acc_full_d;
    logic                   acc_last_q, acc_last_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   done_q, done_d;

    logic                   s_fire, m_fire, last_smp, beat_done, out_free;
    logic [OUT_WIDTH-1:0]   merged;
    logic                   out_load, out_last;
    logic [OUT_WIDTH-1:0]   out_data;
    logic [KEEP_W-1:0]      out_keep;

    assign s_axis_tready = (state_q == PACK) && !acc_full_q;
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign m_fire        = m_axis_tvalid && m_axis_tready;
    assign last_smp      = (smp_cnt_q == SMP_W'(NUM_SAMPLES - 1));
    assign beat_done     = s_fire && (last_smp || (lane_cnt_q == LANE_W'(LANES - 1)));

    // Assembly word with the incoming sample dropped into its lane.
    always_comb begin
        merged = acc_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_cnt_q == LANE_W'(i)) begin
                merged[i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] = s_axis_tdata;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lane_cnt_d  = lane_cnt_q;
        smp_cnt_d   = smp_cnt_q;
        acc_d       = acc_q;
        acc_full_d  = acc_full_q;
        acc_last_d  = acc_last_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        out_load    = 1'b0;
        out_data    = merged;
        out_keep    = '1;
        out_last    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d = PACK;
`ifdef FRAME_HEADER_EN
                    out_load = 1'b1;
                    out_data = OUT_WIDTH'(hdr_word(32'(frame_cnt_q), 16'(NUM_SAMPLES)));
`endif
                end
            end
            PACK: begin
                if (s_fire && last_smp) state_d = DRAIN;
            end
            DRAIN: begin
                if (m_fire && m_axis_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (s_fire) begin
            smp_cnt_d = last_smp ? '0 : smp_cnt_q + SMP_W'(1);
            if (beat_done) begin
                lane_cnt_d = '0;
                if (out_free) begin
                    out_load = 1'b1;
                    out_data = merged;
                    out_keep = last_smp ? LAST_KEEP : '1;
                    out_last = last_smp;
                    acc_d    = '0;
                end else begin
                    acc_d      = merged;
                    acc_full_d = 1'b1;
                    acc_last_d = last_smp;
                end
            end else begin
                acc_d      = merged;
                lane_cnt_d = lane_cnt_q + LANE_W'(1);
            end
        end else if (acc_full_q && out_free) begin
            // Parked beat moves out; clearing acc keeps padding lanes zero.
            out_load   = 1'b1;
            out_data   = acc_q;
            out_keep   = acc_last_q ? LAST_KEEP : '1;
            out_last   = acc_last_q;
            acc_d      = '0;
            acc_full_d = 1'b0;
            acc_last_d = 1'b0;
        end

        if (m_fire && m_axis_tlast) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            done_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lane_cnt_q  <= '0;
            smp_cnt_q   <= '0;
            acc_q       <= '0;
            acc_full_q  <= 1'b0;
            acc_last_q  <= 1'b0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_cnt_q  <= lane_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            acc_q       <= acc_d;
            acc_full_q  <= acc_full_d;
            acc_last_q  <= acc_last_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
        end
    end

    axis_out_reg #(
        .DATA_W(OUT_WIDTH),
        .KEEP_W(KEEP_W)
    ) u_out (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (out_load),
        .data_i  (out_data),
        .keep_i  (out_keep),
        .last_i  (out_last),
        .free_o  (out_free),
        .tvalid_o(m_axis_tvalid),
        .tready_i(m_axis_tready),
        .tdata_o (m_axis_tdata),
        .tkeep_o (m_axis_tkeep),
        .tlast_o (m_axis_tlast)
    );

    assign ap_done   = done_q;
    assign ap_idle   = (state_q == IDLE);
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_prediction_packer.sv
// Scoreboard bench for prediction_packer: a 64-sample instance and a 40-sample (padded) instance.
module tb_prediction_packer;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         a_start, a_done, a_idle, a_svalid, a_sready, a_mvalid, a_mready, a_mlast;
    logic [7:0]   a_sdata;
    logic [255:0] a_mdata;
    logic [31:0]  a_mkeep;
    logic [15:0]  a_fc;
    logic         b_start, b_done, b_idle, b_svalid, b_sready, b_mvalid, b_mready, b_mlast;
    logic [7:0]   b_sdata;
    logic [255:0] b_mdata;
    logic [31:0]  b_mkeep;
    logic [15:0]  b_fc;

    prediction_packer #(
        .PIXEL_BIT_WIDTH(8), .OUT_WIDTH(256), .NUM_SAMPLES(64), .FRAME_CNT_W(16)
    ) dut_a (
        .clk(clk), .reset(reset), .ap_start(a_start), .ap_done(a_done), .ap_idle(a_idle),
        .s_axis_tvalid(a_svalid), .s_axis_tready(a_sready), .s_axis_tdata(a_sdata),
        .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready), .m_axis_tdata(a_mdata),
        .m_axis_tkeep(a_mkeep), .m_axis_tlast(a_mlast), .frame_cnt(a_fc)
    );

    prediction_packer #(
        .PIXEL_BIT_WIDTH(8), .OUT_WIDTH(256), .NUM_SAMPLES(40), .FRAME_CNT_W(16)
    ) dut_b (
        .clk(clk), .reset(reset), .ap_start(b_start), .ap_done(b_done), .ap_idle(b_idle),
        .s_axis_tvalid(b_svalid), .s_axis_tready(b_sready), .s_axis_tdata(b_sdata),
        .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready), .m_axis_tdata(b_mdata),
        .m_axis_tkeep(b_mkeep), .m_axis_tlast(b_mlast), .frame_cnt(b_fc)
    );

    int    checks = 0;
    int    errors = 0;
    beat_t q_a[$];
    beat_t q_b[$];
    int    pend_a = 0, pend_b = 0;
    int    fc_model_a = 0, fc_model_b = 0;
    int    done_a = 0, done_b = 0;
    int    sacc_a = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Expected beats of one frame: sample i carries (base+i), padding lanes zero.
    task automatic push_frame(input bit to_b, input int n, input int base,
                              input logic [31:0] last_keep, input int fc);
        beat_t e;
        int    beats;
        int    idx;
        beats = (n + 31) / 32;
`ifdef FRAME_HEADER_EN
        e = '0;
        e.data[15:0]  = 16'(fc);
        e.data[47:32] = 16'(n);
        e.data[95:64] = 32'h52484544;
        e.keep        = 32'hFFFF_FFFF;
        e.last        = 1'b0;
        if (to_b) q_b.push_back(e); else q_a.push_back(e);
`endif
        for (int b = 0; b < beats; b++) begin
            e = '0;
            for (int k = 0; k < 32; k++) begin
                idx = b * 32 + k;
                if (idx < n) e.data[k*8 +: 8] = 8'(base + idx);
            end
            e.keep = (b == beats - 1) ? last_keep : 32'hFFFF_FFFF;
            e.last = (b == beats - 1);
            if (to_b) q_b.push_back(e); else q_a.push_back(e);
        end
        if (fc < 0) $display("negative frame count %0d", fc);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            q_a.delete();
            pend_a     = 0;
            fc_model_a = 0;
        end else begin
            if (a_svalid && a_sready) sacc_a++;
            if (a_mvalid && a_mready) begin
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_beat: actual %0h required no beat", a_mdata);
                end else begin
                    e = q_a.pop_front();
                    chk("a_tdata", a_mdata, e.data);
                    chk("a_tkeep", 256'(a_mkeep), 256'(e.keep));
                    chk("a_tlast", 256'(a_mlast), 256'(e.last));
                    if (e.last) begin
                        pend_a++;
                        fc_model_a = (fc_model_a + 1) % 65536;
                    end
                end
            end
            if (a_done) begin
                done_a++;
                chk("a_done_after_tlast", 256'(pend_a > 0), 256'(1));
                if (pend_a > 0) pend_a--;
                chk("a_frame_cnt_at_done", 256'(a_fc), 256'(fc_model_a));
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            q_b.delete();
            pend_b     = 0;
            fc_model_b = 0;
        end else begin
            if (b_mvalid && b_mready) begin
                if (q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_beat: actual %0h required no beat", b_mdata);
                end else begin
                    e = q_b.pop_front();
                    chk("b_tdata", b_mdata, e.data);
                    chk("b_tkeep", 256'(b_mkeep), 256'(e.keep));
                    chk("b_tlast", 256'(b_mlast), 256'(e.last));
                    if (e.last) begin
                        pend_b++;
                        fc_model_b = (fc_model_b + 1) % 65536;
                    end
                end
            end
            if (b_done) begin
                done_b++;
                chk("b_done_after_tlast", 256'(pend_b > 0), 256'(1));
                if (pend_b > 0) pend_b--;
                chk("b_frame_cnt_at_done", 256'(b_fc), 256'(fc_model_b));
            end
        end
    end

    task automatic start_a();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    task automatic stream_a(input int n, input int base, input int pulse_at);
        int t;
        bit ok;
        for (int i = 0; i < n; i++) begin
            a_svalid = 1'b1;
            a_sdata  = 8'(base + i);
            if (i == pulse_at) a_start = 1'b1;
            t  = 0;
            ok = 1'b0;
            while (!ok && t < 400) begin
                @(negedge clk);
                ok = a_sready;
                @(posedge clk); #1;
                a_start = 1'b0;
                t++;
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL a_sample_accept: sample %0d not taken after %0d cycles, required taken",
                         i, t);
                break;
            end
        end
        a_svalid = 1'b0;
    endtask

    task automatic stream_b(input int n, input int base);
        int t;
        bit ok;
        for (int i = 0; i < n; i++) begin
            b_svalid = 1'b1;
            b_sdata  = 8'(base + i);
            t  = 0;
            ok = 1'b0;
            while (!ok && t < 400) begin
                @(negedge clk);
                ok = b_sready;
                @(posedge clk); #1;
                t++;
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL b_sample_accept: sample %0d not taken after %0d cycles, required taken",
                         i, t);
                break;
            end
        end
        b_svalid = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int t;
        t = 0;
        while ((q_a.size() != 0 || pend_a != 0) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk(tag, 256'(q_a.size() == 0 && pend_a == 0), 256'(1));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int taken_base;
        a_start = 1'b0; a_svalid = 1'b0; a_sdata = '0; a_mready = 1'b1;
        b_start = 1'b0; b_svalid = 1'b0; b_sdata = '0; b_mready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ap_idle", 256'(a_idle), 256'(1));
        chk("rst_ap_done", 256'(a_done), 256'(0));
        chk("rst_m_tvalid", 256'(a_mvalid), 256'(0));
        chk("rst_s_tready", 256'(a_sready), 256'(0));
        chk("rst_m_tdata", a_mdata, 256'(0));
        chk("rst_m_tkeep", 256'(a_mkeep), 256'(0));
        chk("rst_m_tlast", 256'(a_mlast), 256'(0));
        chk("rst_frame_cnt", 256'(a_fc), 256'(0));
        chk("rst_b_ap_idle", 256'(b_idle), 256'(1));
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: full frame of 64 back-to-back samples
        push_frame(1'b0, 64, 8'h00, 32'hFFFF_FFFF, fc_model_a);
        start_a();
        chk("t1_s_tready_in_pack", 256'(a_sready), 256'(1));
        stream_a(64, 8'h00, -1);
        wait_done_a("t1_frame_drained");
        chk("t1_frame_cnt", 256'(a_fc), 256'(1));
        chk("t1_done_once", 256'(done_a), 256'(1));
        chk("t1_idle", 256'(a_idle), 256'(1));

        // 2: 40-sample frame, last beat padded
        push_frame(1'b1, 40, 8'h00, 32'h0000_00FF, fc_model_b);
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        stream_b(40, 8'h00);
        t = 0;
        while ((q_b.size() != 0 || pend_b != 0) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk("t2_frame_drained", 256'(q_b.size() == 0 && pend_b == 0), 256'(1));
        chk("t2_frame_cnt", 256'(b_fc), 256'(1));
        chk("t2_done_once", 256'(done_b), 256'(1));

        // 3: downstream stalled while streaming a frame
        push_frame(1'b0, 64, 8'h40, 32'hFFFF_FFFF, fc_model_a);
        a_mready   = 1'b0;
        taken_base = sacc_a;
        start_a();
        fork
            stream_a(64, 8'h40, -1);
            begin
                repeat (40) @(negedge clk);
                chk("t3_tdata_held_40", a_mdata, q_a[0].data);
                repeat (40) @(negedge clk);
                chk("t3_s_tready_low", 256'(a_sready), 256'(0));
                chk("t3_m_tvalid_held", 256'(a_mvalid), 256'(1));
                chk("t3_tdata_held_80", a_mdata, q_a[0].data);
`ifdef FRAME_HEADER_EN
                chk("t3_samples_taken", 256'(sacc_a - taken_base), 256'(32));
`else
                chk("t3_samples_taken", 256'(sacc_a - taken_base), 256'(64));
`endif
                @(posedge clk); #1;
                a_mready = 1'b1;
            end
        join
        wait_done_a("t3_frame_drained");
        chk("t3_frame_cnt", 256'(a_fc), 256'(2));

        // 5: ap_start during PACK and on the tlast handshake cycle is ignored
        push_frame(1'b0, 64, 8'h10, 32'hFFFF_FFFF, fc_model_a);
        start_a();
        stream_a(64, 8'h10, 10);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(a_mvalid && a_mlast) && t < 200);
        chk("t5_tlast_seen", 256'(a_mvalid && a_mlast), 256'(1));
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_idle_after_ignored_start", 256'(a_idle), 256'(1));
        chk("t5_s_tready_low", 256'(a_sready), 256'(0));
        chk("t5_frame_cnt", 256'(a_fc), 256'(3));
        @(posedge clk); #1;
        push_frame(1'b0, 64, 8'h55, 32'hFFFF_FFFF, fc_model_a);
        start_a();
        stream_a(64, 8'h55, -1);
        wait_done_a("t5b_frame_drained");
        chk("t5b_frame_cnt", 256'(a_fc), 256'(4));

        // 4: reset mid-frame, then a clean frame from lane 0
        push_frame(1'b0, 64, 8'h20, 32'hFFFF_FFFF, fc_model_a);
        a_mready = 1'b0;
        start_a();
        stream_a(32, 8'h20, -1);
        chk("t4_m_tvalid_before_reset", 256'(a_mvalid), 256'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("t4_m_tvalid_async_drop", 256'(a_mvalid), 256'(0));
        chk("t4_ap_idle", 256'(a_idle), 256'(1));
        chk("t4_frame_cnt_cleared", 256'(a_fc), 256'(0));
        chk("t4_s_tready", 256'(a_sready), 256'(0));
        chk("t4_m_tdata_cleared", a_mdata, 256'(0));
        @(posedge clk);
        @(posedge clk); #1;
        reset    = 1'b0;
        a_mready = 1'b1;
        @(posedge clk); #1;
        push_frame(1'b0, 64, 8'h80, 32'hFFFF_FFFF, fc_model_a);
        start_a();
        stream_a(64, 8'h80, -1);
        wait_done_a("t4_frame_drained");
        chk("t4_frame_cnt_after", 256'(a_fc), 256'(1));
        chk("total_done_pulses", 256'(done_a), 256'(5));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
